// File: rtl/count_scan_ctrl_pkg.sv
// Shared types for the counter display sequencer: digit type, digit ceiling and control states.
package count_scan_pkg;

  typedef logic [2:0] digit_t;

  localparam digit_t DIGIT_MAX = 3'd5;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/count_scan_ctrl_if.sv
// Control and display bundle between the board-side logic and count_scan_ctrl.
interface count_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import count_scan_pkg::*;

  logic                  run;
  logic                  dir;
  logic                  clear;
  logic                  step;
  digit_t                q;
  logic [NUM_DIGITS-1:0] anode;
  logic                  tick;
  logic                  wrap;

  modport master (
    output run, dir, clear, step,
    input  q, anode, tick, wrap
  );

  modport slave (
    input  run, dir, clear, step,
    output q, anode, tick, wrap
  );

endinterface

// File: rtl/count_scan_ctrl_base6_digit.sv
// One base-6 digit with carry/borrow in and a combinational carry/borrow out.
module base6_digit
  import count_scan_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   en,
  input  logic   dir,
  input  logic   cin,
  output digit_t value,
  output logic   cout
);

  logic at_limit;

  assign at_limit = dir ? (value == 3'd0) : (value == DIGIT_MAX);
  assign cout     = en & cin & at_limit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= 3'd0;
    end else if (en && cin) begin
      if (at_limit) begin
        value <= dir ? DIGIT_MAX : 3'd0;
      end else begin
        value <= dir ? (value - 3'd1) : (value + 3'd1);
      end
    end
  end

endmodule

// File: rtl/count_scan_ctrl.sv
// Counter display sequencer: PAUSED/RUN control, tick prescaler, cascaded base-6 digits and
// a time-multiplexed digit scan onto one 3-bit value bus with active-low anodes.
module count_scan_ctrl
  import count_scan_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  count_scan_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  ctrl_state_t           state, state_nxt;
  logic [PW-1:0]         presc, presc_nxt;
  logic                  tick_reg;
  logic                  adv;
  logic                  en;
  logic                  wrap_reg;
  logic [SW-1:0]         scan_div;
  logic [IW-1:0]         scan_idx;
  digit_t                q_reg;
  logic [NUM_DIGITS-1:0] anode_reg;
  digit_t                digits [NUM_DIGITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PAUSED;
      presc    <= '0;
      tick_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      tick_reg <= (state_nxt == RUN) && (presc_nxt == PRE_LAST);
    end
  end

  // tick_reg mirrors presc == TICK_DIV-1 in RUN, so it doubles as the RUN advance event
  always_comb begin
    state_nxt = bus.run ? RUN : PAUSED;
    presc_nxt = '0;
    adv       = 1'b0;
    if (state == RUN) begin
      adv = tick_reg;
      if (bus.run && !bus.clear && (presc != PRE_LAST)) begin
        presc_nxt = presc + 1'b1;
      end
    end else begin
      adv = bus.step;
    end
  end

  assign en = adv & ~bus.clear;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_next
      assign cin = g_digit[i-1].cout;
    end
    base6_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .en    (en),
      .dir   (bus.dir),
      .cin   (cin),
      .value (digits[i]),
      .cout  (cout)
    );
  end

  // wrap lands on the same edge as the rolled-over digit values
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= g_digit[NUM_DIGITS-1].cout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_div <= '0;
      scan_idx <= '0;
    end else if (scan_div == SCAN_LAST) begin
      scan_div <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_div <= scan_div + 1'b1;
    end
  end

  // Output stage: q and anode sampled together so they never disagree on the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg     <= 3'd0;
      anode_reg <= ~NUM_DIGITS'(1);
    end else begin
      q_reg     <= digits[scan_idx];
      anode_reg <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

  assign bus.q     = q_reg;
  assign bus.anode = anode_reg;
  assign bus.tick  = tick_reg;
  assign bus.wrap  = wrap_reg;

endmodule

// File: doc/count_scan_ctrl.md
# count_scan_ctrl

Sequencing controller for the counter display. Owns a NUM_DIGITS-digit base-6 counter (each digit 0..5), advances it from a prescaled tick or a single-step request, and time-multiplexes the digits onto one shared 3-bit value bus. That bus drives the existing 3-bit-to-7-segment decoder; the per-digit anode enables go straight to the board.

## Interface
- TICK_DIV, 100_000_000: clk cycles per count tick in RUN; legal range ≥ 2.
- SCAN_DIV, 100_000: clk cycles per digit slot in the display scan; legal range ≥ 1.
- NUM_DIGITS, 4: number of cascaded base-6 digits; legal range 1..8.
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = count on ticks, 0 = paused.
- dir  in  1  0 = count up, 1 = count down.
- clear  in  1  one-cycle pulse; zero all digits.
- step  in  1  one-cycle pulse; advance by one while paused.
- q  out  3  value of currently scanned digit, 0..5, to decoder.
- anode  out  NUM_DIGITS  active-low one-hot digit enable, aligned with q.
- tick  out  1  one-cycle pulse per prescaler expiry.
- wrap  out  1  one-cycle pulse when the full counter rolls over or under.

## Operation
- Reset priority: reset > clear > advance.
- Reset values:
  - all digits 0, state PAUSED, prescaler 0, scan index 0, scan divider 0.
  - q = 0, anode = all ones except bit 0 = 0, tick = 0, wrap = 0.
- State machine PAUSED / RUN, evaluated every cycle:
  - PAUSED → RUN when run = 1.
  - RUN → PAUSED when run = 0; the prescaler clears to 0 on that transition.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - At TICK_DIV-1 it asserts tick for that cycle and returns to 0.
- Advance events:
  - In RUN, tick is the only advance event; step is ignored.
  - In PAUSED, step is the advance event.
- Advance, up: digit 0 increments. A digit at 5 goes to 0 and carries into the next digit.
- Advance, down: digit 0 decrements. A digit at 0 goes to 5 and borrows from the next digit.
- Wrap:
  - Carry out of digit NUM_DIGITS-1 (all 5s → all 0s) pulses wrap for one cycle.
  - Borrow out of digit NUM_DIGITS-1 (all 0s → all 5s) also pulses wrap for one cycle.
- dir is sampled on the advance cycle only; a change between advances has no other effect.
- clear:
  - Zeroes all digits and the prescaler.
  - Suppresses any advance, and the wrap it would cause, in the same cycle.
  - tick may still pulse in that cycle.
  - Does not change state, scan index or anode.
- Scan:
  - The scan divider counts 0..SCAN_DIV-1 continuously, in both states.
  - At expiry the scan index advances, wrapping NUM_DIGITS-1 → 0.
  - q and anode are registered from the scan index and digit values and always change in the same cycle.
- Digit values are never outside 0..5; 6 and 7 are unreachable.

## Timing
- Digit registers update on the clock edge following the tick/step cycle; latency is 1.
- wrap is asserted in the same cycle the new digit values first appear.
- q reflects a digit update 1 cycle after the digit register changes, when that digit is being scanned.
- A digit-slot change appears on q/anode 1 cycle after scan-divider expiry.
- tick is combinationally high during prescaler count TICK_DIV-1, registered output, one cycle wide.
- The first tick after entering RUN comes TICK_DIV cycles after run is sampled high.
- Reset asserted mid-count or mid-scan restores all reset values on the next edge. No partial state survives.
- step and clear are not edge-detected; a pulse held for N cycles acts N times.

## Structure
- Package count_scan_pkg holds:
  - typedef digit_t (3-bit).
  - DIGIT_MAX = 5.
  - enum ctrl_state_t {PAUSED, RUN}.
- Sub-module base6_digit, one per digit.
  - Inputs: clk, reset, clear, en, dir, cin (carry/borrow in).
  - Outputs: value (digit_t), cout (carry/borrow out, combinational).
  - Chained via generate; en of digit 0 is the advance event.
- The top level holds the FSM, prescaler, scan divider and output registers.
- The decoder stays external.

## Test plan
All scenarios use TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=2.
1. Reset release, run=0 for 20 cycles → digits 00; q=0 and anode alternates 10/01 every 2 cycles; tick never pulses.
2. run=1, dir=0 for 36 ticks → digits count 00,01..05,10..55,00; wrap pulses exactly once, on the 55→00 transition; tick period exactly 4 cycles.
3. Paused at 00, dir=1, one step pulse → digits 55 one cycle later; wrap pulses once; q shows 5 in both scan slots.
4. In RUN, clear asserted in the cycle tick is high with digits 05 → digits 00 next cycle, no advance, no wrap; next tick is 4 cycles later.
5. run toggled 1→0 after 2 cycles of prescaler count, then 1 again → no tick during the pause; first tick 4 cycles after resume; step pulses during RUN are ignored.
6. reset asserted mid-scan with digits 34 → next edge: digits 00, q=0, anode=10, tick=0, wrap=0, state PAUSED.
